// File: rtl/overlay_pkg.sv
// Shared types, class colour table and overlay colour mapping for the class overlay stream.
package overlay_pkg;

  localparam int OV_PIX_W       = 24;
  localparam int OV_CLASS_W     = 3;
  localparam int OV_NUM_CLASSES = 8;

  typedef enum logic [1:0] {
    OV_PASS    = 2'd0,
    OV_REPLACE = 2'd1,
    OV_BLEND   = 2'd2
  } ov_mode_e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_IN_FRAME = 1'b1
  } ov_state_e;

  // Display colour for each class; class 0 is background and is never painted.
  localparam logic [23:0] CLASS_RGB [OV_NUM_CLASSES] = '{
    24'h000000, 24'hFF0000, 24'h00FF00, 24'h0000FF,
    24'hFFFF00, 24'hFF00FF, 24'h00FFFF, 24'hFFFFFF
  };

  // The unused mode code 3 behaves as pass-through.
  function automatic ov_mode_e decode_mode(input logic [1:0] m);
    ov_mode_e res;
    case (m)
      2'd1:    res = OV_REPLACE;
      2'd2:    res = OV_BLEND;
      default: res = OV_PASS;
    endcase
    return res;
  endfunction

  // Blend halves both operands before adding so each channel stays within 8 bits.
  function automatic logic [23:0] overlay_pixel(input logic [23:0] pix,
                                                input logic [2:0]  cls,
                                                input ov_mode_e    m);
    logic [23:0] col;
    logic [23:0] res;
    col = CLASS_RGB[cls];
    res = pix;
    if (cls != 3'd0) begin
      case (m)
        OV_REPLACE: res = col;
        OV_BLEND: begin
          res[23:16] = (pix[23:16] >> 1) + (col[23:16] >> 1);
          res[15:8]  = (pix[15:8]  >> 1) + (col[15:8]  >> 1);
          res[7:0]   = (pix[7:0]   >> 1) + (col[7:0]   >> 1);
        end
        default: res = pix;
      endcase
    end
    return res;
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Output register plus one-entry skid slot; in_ready is the registered "skid empty" flag.
module stream_skid_buf #(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         skid_valid;
  logic [W-1:0] skid_data;

  assign in_ready = !skid_valid;

  // Refill the output register from the skid first so order is kept; park a beat in the skid when stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (!out_valid || out_ready) begin
      if (skid_valid) begin
        out_data   <= skid_data;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= in_valid;
        if (in_valid) begin
          out_data <= in_data;
        end
      end
    end else if (in_valid && !skid_valid) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end

endmodule

// File: rtl/class_overlay_gen.sv
// Overlays class colours on the classified pixel stream and publishes per-class pixel counts per frame.
module class_overlay_gen
  import overlay_pkg::*;
#(
  parameter int PIX_W   = 24,
  parameter int CLASS_W = 3,
  parameter int CNT_W   = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         mode,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PIX_W-1:0]   in_pixel,
  input  logic [CLASS_W-1:0] in_class,
  input  logic               in_sop,
  input  logic               in_eop,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PIX_W-1:0]   out_pixel,
  output logic               out_sop,
  output logic               out_eop,
  output logic [8*CNT_W-1:0] class_count,
  output logic               count_valid
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  ov_state_e        state;
  ov_mode_e         active_mode;
  ov_mode_e         beat_mode;
  logic             in_fire;
  logic             counting;
  logic [PIX_W-1:0] mapped_pixel;
  logic [PIX_W+1:0] out_payload;
  logic [CNT_W-1:0] cnt      [8];
  logic [CNT_W-1:0] cnt_next [8];

  assign in_fire  = in_valid && in_ready;
  assign counting = in_sop || (state == ST_IN_FRAME);

  // A start-of-frame beat already uses the newly requested mode; beats outside a frame pass through.
  always_comb begin
    beat_mode = OV_PASS;
    if (in_sop) begin
      beat_mode = decode_mode(mode);
    end else if (state == ST_IN_FRAME) begin
      beat_mode = active_mode;
    end
  end

  assign mapped_pixel = overlay_pixel(in_pixel, in_class, beat_mode);

  // Counter values after this beat: a new frame starts from zero, and counts stick at all-ones.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      cnt_next[k] = in_sop ? '0 : cnt[k];
      if ((in_class == CLASS_W'(k)) && (cnt_next[k] != CNT_MAX)) begin
        cnt_next[k] = cnt_next[k] + CNT_W'(1);
      end
    end
  end

  // Frame tracking and counting on input acceptance, independent of output backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      active_mode <= OV_PASS;
      class_count <= '0;
      count_valid <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        cnt[k] <= '0;
      end
    end else begin
      count_valid <= 1'b0;
      if (in_fire && counting) begin
        for (int k = 0; k < 8; k++) begin
          cnt[k] <= cnt_next[k];
        end
        if (in_eop) begin
          state       <= ST_IDLE;
          active_mode <= OV_PASS;
          count_valid <= 1'b1;
          for (int k = 0; k < 8; k++) begin
            class_count[k*CNT_W +: CNT_W] <= cnt_next[k];
          end
        end else begin
          state <= ST_IN_FRAME;
          if (in_sop) begin
            active_mode <= decode_mode(mode);
          end
        end
      end
    end
  end

  stream_skid_buf #(
    .W(PIX_W + 2)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({in_sop, in_eop, mapped_pixel}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_payload)
  );

  assign out_sop   = out_payload[PIX_W+1];
  assign out_eop   = out_payload[PIX_W];
  assign out_pixel = out_payload[PIX_W-1:0];

endmodule

// File: tb/tb_class_overlay_gen.sv
// Self-checking bench for class_overlay_gen: directed frames plus a randomized backpressure frame.
module tb_class_overlay_gen;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   mode = '0;
  logic         in_valid = 1'b0;
  logic [23:0]  in_pixel = '0;
  logic [2:0]   in_class = '0;
  logic         in_sop = 1'b0;
  logic         in_eop = 1'b0;
  logic         out_ready = 1'b0;
  logic         in_ready, out_valid, out_sop, out_eop, count_valid;
  logic [23:0]  out_pixel;
  logic [159:0] class_count;
  logic         in_ready_s, out_valid_s, out_sop_s, out_eop_s, count_valid_s;
  logic [23:0]  out_pixel_s;
  logic [31:0]  class_count_s;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [25:0]  exp_q[$];
  int           model_counts[8];
  bit           m_in_frame = 0;
  int           m_mode = 0;
  bit           pending = 0;
  logic [159:0] exp_main = '0;
  logic [159:0] exp_sat = '0;
  int           rgb_tab[8] = '{32'h000000, 32'hFF0000, 32'h00FF00, 32'h0000FF,
                               32'hFFFF00, 32'hFF00FF, 32'h00FFFF, 32'hFFFFFF};

  always #5 clk = ~clk;

  class_overlay_gen #(.PIX_W(24), .CLASS_W(3), .CNT_W(20)) dut (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_pixel(in_pixel), .in_class(in_class), .in_sop(in_sop), .in_eop(in_eop),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
    .out_sop(out_sop), .out_eop(out_eop), .class_count(class_count), .count_valid(count_valid)
  );

  class_overlay_gen #(.PIX_W(24), .CLASS_W(3), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_pixel(in_pixel), .in_class(in_class), .in_sop(in_sop), .in_eop(in_eop),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_pixel(out_pixel_s),
    .out_sop(out_sop_s), .out_eop(out_eop_s), .class_count(class_count_s), .count_valid(count_valid_s)
  );

  task automatic checkOutput(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] modelPixel(input logic [23:0] p, input int cls, input int m);
    int c, r, g, b;
    if (cls == 0 || m == 0) return p;
    c = rgb_tab[cls];
    if (m == 1) return 24'(c);
    r = ((int'(p) >> 16) & 255) / 2 + ((c >> 16) & 255) / 2;
    g = ((int'(p) >> 8) & 255) / 2 + ((c >> 8) & 255) / 2;
    b = (int'(p) & 255) / 2 + (c & 255) / 2;
    return 24'((r << 16) | (g << 8) | b);
  endfunction

  function automatic logic [159:0] packCounts(input int w);
    logic [159:0] v;
    int mx;
    v = '0;
    mx = (1 << w) - 1;
    for (int k = 0; k < 8; k++) begin
      v = v | (160'((model_counts[k] > mx) ? mx : model_counts[k]) << (k * w));
    end
    return v;
  endfunction

  task automatic modelAccept(input bit sop, input bit eop, input logic [23:0] pix,
                             input logic [2:0] cls, input logic [1:0] md);
    int m;
    if (sop) begin
      m_in_frame = 1;
      m_mode = (md == 2'd3) ? 0 : int'(md);
      for (int k = 0; k < 8; k++) model_counts[k] = 0;
    end
    m = m_in_frame ? m_mode : 0;
    exp_q.push_back({sop, eop, modelPixel(pix, int'(cls), m)});
    if (m_in_frame) begin
      model_counts[cls]++;
      if (eop) begin
        exp_main = packCounts(20);
        exp_sat = packCounts(4);
        pending = 1;
        m_in_frame = 0;
      end
    end
  endtask

  // One clock cycle: check count outputs, drive inputs, score output and input transfers.
  task automatic applyStimulus(input bit v, input bit sop, input bit eop, input logic [23:0] pix,
                               input logic [2:0] cls, input logic [1:0] md, input bit ordy,
                               output bit accepted);
    logic [25:0] e;
    @(negedge clk);
    checkOutput("count_valid", 160'(count_valid), 160'(pending));
    checkOutput("count_valid_sat", 160'(count_valid_s), 160'(pending));
    checkOutput("class_count", class_count, exp_main);
    checkOutput("class_count_sat", 160'(class_count_s), exp_sat);
    pending = 0;
    in_valid = v; in_sop = sop; in_eop = eop; in_pixel = pix; in_class = cls;
    mode = md; out_ready = ordy;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("out_unexpected_beat", 160'(1), 160'(0));
      end else begin
        e = exp_q.pop_front();
        checkOutput("out_beat", 160'({out_sop, out_eop, out_pixel}), 160'(e));
        checkOutput("out_beat_sat", 160'({out_sop_s, out_eop_s, out_pixel_s}), 160'(e));
      end
    end
    accepted = in_valid && in_ready;
    if (accepted) modelAccept(sop, eop, pix, cls, md);
  endtask

  task automatic idleCycle();
    bit acc;
    applyStimulus(0, 0, 0, 24'h0, 3'd0, 2'd0, 1, acc);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && !out_valid) && n < 50) begin
      idleCycle();
      n++;
    end
    if (n >= 50) checkOutput("drain_timeout", 160'(1), 160'(0));
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst = 1; in_valid = 0; in_sop = 0; in_eop = 0; out_ready = 0;
    repeat (2) @(negedge clk);
    checkOutput("rst_out_valid", 160'(out_valid), 160'(0));
    checkOutput("rst_count_valid", 160'(count_valid), 160'(0));
    checkOutput("rst_class_count", class_count, 160'(0));
    rst = 0;
    exp_q.delete();
    m_in_frame = 0; pending = 0; exp_main = '0; exp_sat = '0;
    @(negedge clk);
    checkOutput("rst_in_ready", 160'(in_ready), 160'(1));
    checkOutput("rst_out_valid_after", 160'(out_valid), 160'(0));
  endtask

  initial begin
    bit acc;
    int idx, cyc, sum, fmode, v;
    logic [23:0] cur_pix;
    logic [2:0] cur_cls;
    logic [159:0] expv;

    $display("[TB] reset");
    resetDut();

    $display("[TB] replace frame");
    applyStimulus(1, 1, 0, 24'h808080, 3'd1, 2'd1, 1, acc);
    checkOutput("rep_accept", 160'(acc), 160'(1));
    applyStimulus(1, 0, 0, 24'h808080, 3'd2, 2'd0, 1, acc);
    checkOutput("rep_lat0", 160'({out_valid, out_pixel}), 160'({1'b1, 24'hFF0000}));
    applyStimulus(1, 0, 0, 24'h808080, 3'd0, 2'd0, 1, acc);
    checkOutput("rep_lat1", 160'({out_valid, out_pixel}), 160'({1'b1, 24'h00FF00}));
    applyStimulus(1, 0, 1, 24'h808080, 3'd7, 2'd0, 1, acc);
    checkOutput("rep_throughput", 160'(acc), 160'(1));
    checkOutput("rep_lat2", 160'({out_valid, out_pixel}), 160'({1'b1, 24'h808080}));
    idleCycle();
    checkOutput("rep_lat3", 160'({out_valid, out_pixel}), 160'({1'b1, 24'hFFFFFF}));
    checkOutput("rep_count_valid", 160'(count_valid), 160'(1));
    expv = '0;
    expv[0 +: 20] = 20'd1; expv[20 +: 20] = 20'd1; expv[40 +: 20] = 20'd1; expv[140 +: 20] = 20'd1;
    checkOutput("rep_counts", class_count, expv);
    idleCycle();
    checkOutput("rep_count_pulse_end", 160'(count_valid), 160'(0));

    $display("[TB] blend frame");
    applyStimulus(1, 1, 0, 24'h204060, 3'd3, 2'd2, 1, acc);
    applyStimulus(1, 0, 1, 24'h204060, 3'd0, 2'd0, 1, acc);
    // (0x60>>1)+(0xFF>>1) = 0x30+0x7F = 0xAF
    checkOutput("blend_class3", 160'(out_pixel), 160'(24'h1020AF));
    idleCycle();
    checkOutput("blend_class0", 160'(out_pixel), 160'(24'h204060));
    drain();

    $display("[TB] backpressure frame");
    idx = 0; cyc = 0;
    cur_pix = 24'($urandom); cur_cls = 3'($urandom_range(0, 7));
    fmode = $urandom_range(1, 2);
    while (idx < 1000 && cyc < 10000) begin
      v = ($urandom_range(0, 3) != 0) ? 1 : 0;
      applyStimulus(v[0], idx == 0, idx == 999, cur_pix, cur_cls, 2'(fmode),
                    1'($urandom_range(0, 1)), acc);
      if (acc) begin
        idx++;
        cur_pix = 24'($urandom);
        cur_cls = 3'($urandom_range(0, 7));
      end
      cyc++;
    end
    checkOutput("bp_all_accepted", 160'(idx), 160'(1000));
    drain();
    idleCycle();
    sum = 0;
    for (int k = 0; k < 8; k++) sum += int'(class_count[k*20 +: 20]);
    checkOutput("bp_count_sum", 160'(sum), 160'(1000));

    $display("[TB] framing");
    applyStimulus(1, 1, 0, 24'h111111, 3'd2, 2'd1, 1, acc);
    applyStimulus(1, 0, 0, 24'h222222, 3'd3, 2'd0, 1, acc);
    applyStimulus(1, 0, 0, 24'h333333, 3'd3, 2'd0, 1, acc);
    applyStimulus(1, 1, 0, 24'h444444, 3'd1, 2'd2, 1, acc);
    applyStimulus(1, 0, 1, 24'h555555, 3'd6, 2'd0, 1, acc);
    idleCycle();
    expv = '0;
    expv[20 +: 20] = 20'd1; expv[120 +: 20] = 20'd1;
    checkOutput("abort_counts", class_count, expv);
    applyStimulus(1, 1, 1, 24'h0A0B0C, 3'd5, 2'd1, 1, acc);
    idleCycle();
    checkOutput("single_count_valid", 160'(count_valid), 160'(1));
    checkOutput("single_counts", class_count, 160'(20'd1) << 100);
    applyStimulus(1, 0, 1, 24'h0D0E0F, 3'd2, 2'd1, 1, acc);
    idleCycle();
    checkOutput("idle_eop_no_pulse", 160'(count_valid), 160'(0));
    checkOutput("idle_eop_kept", class_count, 160'(20'd1) << 100);
    drain();

    $display("[TB] saturation");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, i == 0, i == 19, 24'($urandom), 3'd4, 2'd0, 1, acc);
    end
    idleCycle();
    checkOutput("sat_wide", 160'(class_count[80 +: 20]), 160'(20));
    checkOutput("sat_narrow", 160'(class_count_s[16 +: 4]), 160'(15));
    drain();

    $display("[TB] stall and mid-frame reset");
    applyStimulus(1, 1, 0, 24'h123456, 3'd1, 2'd1, 0, acc);
    applyStimulus(1, 0, 0, 24'h654321, 3'd2, 2'd0, 0, acc);
    checkOutput("stall_skid_accept", 160'(acc), 160'(1));
    applyStimulus(1, 0, 0, 24'hABCDEF, 3'd3, 2'd0, 0, acc);
    checkOutput("stall_in_ready_low", 160'(acc), 160'(0));
    resetDut();
    idleCycle();
    idleCycle();
    checkOutput("post_rst_no_beat", 160'(out_valid), 160'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
